// File: rtl/cdb_scheduler.sv
// ----------------------------------------------------------------------------
// cdb_scheduler
//
// Common-data-bus scheduler and label-table controller for a bank of tagged
// registers. Each register in the bank holds a DW-bit value and an LW-bit
// label and is loaded through its own DataControl / LabelControl enables.
//
// Function:
//   - Round-robin arbitration of the CDB among NREQ functional-unit requesters
//     (one-hot, combinational grant in the request cycle).
//   - One registered broadcast per cycle (valid / data / label).
//   - A shadow label table, one entry per register, that mirrors what the
//     register bank holds and decides which registers capture a broadcast.
//   - Issue-stage relabelling of a destination register; on a collision with
//     a writeback to the same register the data is still captured but the
//     newly issued label wins.
//
// Ports:
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   issue_valid     in   one instruction issued this cycle
//   issue_reg       in   [RAW]       destination register of the issue
//   issue_tag       in   [LW]        producer label for that register
//   fu_req          in   [NREQ]      per-requester CDB request (held to grant)
//   fu_data         in   [NREQ*DW]   packed results, requester i at [i*DW +: DW]
//   fu_tag          in   [NREQ*LW]   packed labels,  requester i at [i*LW +: LW]
//   fu_gnt          out  [NREQ]      one-hot grant, combinational
//   cdb_valid       out              registered broadcast valid
//   cdb_data        out  [DW]        registered broadcast data
//   cdb_tag         out  [LW]        registered broadcast label
//   reg_data_ctrl   out  [NREG]      per-register DataControl
//   reg_label_ctrl  out  [NREG]      per-register LabelControl
//   reg_wdata       out  [DW]        data for every register (= cdb_data)
//   reg_wlabel      out  [NREG*LW]   label to load into each register
//
// Optional status outputs, present only when CDB_STATUS_EN is defined:
//   reg_busy        out  [NREG]      registered copy of (label[i] != FREE)
//   busy_cnt        out  [RAW+1]     registered population count of busy labels
// ----------------------------------------------------------------------------
module cdb_scheduler #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned RAW  = 3,
    parameter int unsigned DW   = 12,
    parameter int unsigned LW   = 2,
    localparam int unsigned NREG = 2 ** RAW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [RAW-1:0]       issue_reg,
    input  logic [LW-1:0]        issue_tag,
    input  logic [NREQ-1:0]      fu_req,
    input  logic [NREQ*DW-1:0]   fu_data,
    input  logic [NREQ*LW-1:0]   fu_tag,
    output logic [NREQ-1:0]      fu_gnt,
    output logic                 cdb_valid,
    output logic [DW-1:0]        cdb_data,
    output logic [LW-1:0]        cdb_tag,
    output logic [NREG-1:0]      reg_data_ctrl,
    output logic [NREG-1:0]      reg_label_ctrl,
    output logic [DW-1:0]        reg_wdata,
    output logic [NREG*LW-1:0]   reg_wlabel
`ifdef CDB_STATUS_EN
    ,
    output logic [NREG-1:0]      reg_busy,
    output logic [RAW:0]         busy_cnt
`endif
);

    // Label meaning "value valid, no pending producer".
    localparam logic [LW-1:0] FREE = '1;
    localparam int unsigned   PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    // ------------------------------------------------------------------
    // Unpack the requester buses so they can be indexed by grant number.
    // ------------------------------------------------------------------
    logic [DW-1:0] fu_data_a [NREQ];
    logic [LW-1:0] fu_tag_a  [NREQ];

    for (genvar q = 0; q < NREQ; q++) begin : g_unpack
        assign fu_data_a[q] = fu_data[q*DW +: DW];
        assign fu_tag_a[q]  = fu_tag[q*LW +: LW];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]              ptr_q, ptr_d;
    logic                       cdb_valid_q, cdb_valid_d;
    logic [DW-1:0]              cdb_data_q, cdb_data_d;
    logic [LW-1:0]              cdb_tag_q, cdb_tag_d;
    logic [NREG-1:0][LW-1:0]    label_q, label_d;

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan from the slot after the last winner and
    // wrap; the first active request wins. The pointer only moves on a
    // grant, so an idle cycle keeps the current priority order.
    // ------------------------------------------------------------------
    logic          gnt_any;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] scan_idx;

    always_comb begin : arbiter
        fu_gnt   = '0;
        gnt_any  = 1'b0;
        gnt_idx  = ptr_q;
        scan_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_idx = PW'((32'(ptr_q) + k) % NREQ);
            if (!gnt_any && fu_req[scan_idx]) begin
                fu_gnt[scan_idx] = 1'b1;
                gnt_idx          = scan_idx;
                gnt_any          = 1'b1;
            end
        end
    end

    // Broadcast capture: the winner's result goes on the bus next cycle.
    // Without a grant the payload simply holds; valid drops.
    always_comb begin : bcast_next
        cdb_valid_d = gnt_any;
        cdb_data_d  = cdb_data_q;
        cdb_tag_d   = cdb_tag_q;
        ptr_d       = ptr_q;
        if (gnt_any) begin
            cdb_data_d = fu_data_a[gnt_idx];
            cdb_tag_d  = fu_tag_a[gnt_idx];
            ptr_d      = gnt_idx;
        end
    end

    // ------------------------------------------------------------------
    // Writeback and issue. A live broadcast (valid, non-FREE label) is
    // captured by every register whose table label matches. An issue with
    // a non-FREE label relabels its destination; on a collision the data
    // is still loaded but the issued label overrides the FREE writeback.
    // ------------------------------------------------------------------
    logic cdb_live;
    logic issue_live;

    assign cdb_live   = cdb_valid_q && (cdb_tag_q != FREE);
    assign issue_live = issue_valid && (issue_tag != FREE);

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        logic wb_hit;
        logic iss_hit;

        assign wb_hit  = cdb_live && (label_q[r] == cdb_tag_q);
        assign iss_hit = issue_live && (issue_reg == RAW'(r));

        assign reg_data_ctrl[r]        = wb_hit;
        assign reg_label_ctrl[r]       = wb_hit | iss_hit;
        assign reg_wlabel[r*LW +: LW]  = iss_hit ? issue_tag : FREE;
        assign label_d[r]              = iss_hit ? issue_tag :
                                         (wb_hit ? FREE : label_q[r]);
    end

    // ------------------------------------------------------------------
    // Registers. Reset drops any pending broadcast and frees every label;
    // requester 0 gets first priority afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= PW'(NREQ - 1);
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_tag_q   <= FREE;
            label_q     <= {NREG{FREE}};
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_tag_q   <= cdb_tag_d;
            label_q     <= label_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_tag   = cdb_tag_q;
    assign reg_wdata = cdb_data_q;

`ifdef CDB_STATUS_EN
    // ------------------------------------------------------------------
    // Status view of the label table, one cycle behind the table itself.
    // ------------------------------------------------------------------
    localparam int unsigned CW = RAW + 1;

    logic [NREG-1:0] busy_now;
    logic [NREG-1:0] reg_busy_q;
    logic [CW-1:0]   busy_cnt_q;

    for (genvar b = 0; b < NREG; b++) begin : g_busy
        assign busy_now[b] = (label_q[b] != FREE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_busy_q <= '0;
            busy_cnt_q <= '0;
        end else begin
            reg_busy_q <= busy_now;
            busy_cnt_q <= CW'($countones(busy_now));
        end
    end

    assign reg_busy = reg_busy_q;
    assign busy_cnt = busy_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_scheduler.sv
// ----------------------------------------------------------------------------
// tb_cdb_scheduler
//
// Self-checking bench for cdb_scheduler. A behavioural model (integer label
// array, round-robin pointer, broadcast register) predicts grant, broadcast
// and register-bank enables every cycle; directed scenarios add explicit
// constant checks, then a randomized phase exercises mixed traffic.
// ----------------------------------------------------------------------------
module tb_cdb_scheduler;

    localparam int NREQ = 3;
    localparam int RAW  = 3;
    localparam int DW   = 12;
    localparam int LW   = 2;
    localparam int NREG = 8;
    localparam int FREE = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 issue_valid;
    logic [RAW-1:0]       issue_reg;
    logic [LW-1:0]        issue_tag;
    logic [NREQ-1:0]      fu_req;
    logic [NREQ*DW-1:0]   fu_data;
    logic [NREQ*LW-1:0]   fu_tag;
    logic [NREQ-1:0]      fu_gnt;
    logic                 cdb_valid;
    logic [DW-1:0]        cdb_data;
    logic [LW-1:0]        cdb_tag;
    logic [NREG-1:0]      reg_data_ctrl;
    logic [NREG-1:0]      reg_label_ctrl;
    logic [DW-1:0]        reg_wdata;
    logic [NREG*LW-1:0]   reg_wlabel;
`ifdef CDB_STATUS_EN
    logic [NREG-1:0]      reg_busy;
    logic [RAW:0]         busy_cnt;
`endif

    always #5 clk = ~clk;

    cdb_scheduler #(
        .NREQ (NREQ),
        .RAW  (RAW),
        .DW   (DW),
        .LW   (LW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_reg      (issue_reg),
        .issue_tag      (issue_tag),
        .fu_req         (fu_req),
        .fu_data        (fu_data),
        .fu_tag         (fu_tag),
        .fu_gnt         (fu_gnt),
        .cdb_valid      (cdb_valid),
        .cdb_data       (cdb_data),
        .cdb_tag        (cdb_tag),
        .reg_data_ctrl  (reg_data_ctrl),
        .reg_label_ctrl (reg_label_ctrl),
        .reg_wdata      (reg_wdata),
        .reg_wlabel     (reg_wlabel)
`ifdef CDB_STATUS_EN
        ,
        .reg_busy       (reg_busy),
        .busy_cnt       (busy_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int m_lbl [NREG];
    int m_ptr;
    bit m_cv;
    int m_cd;
    int m_ct;
    int m_last_g;

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) m_lbl[r] = FREE;
        m_ptr    = NREQ - 1;
        m_cv     = 1'b0;
        m_cd     = 0;
        m_ct     = FREE;
        m_last_g = -1;
    endtask

    function automatic int model_grant();
        for (int k = 1; k <= NREQ; k++)
            if (fu_req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic bit wb_match(int r);
        return m_cv && (m_ct != FREE) && (m_lbl[r] == m_ct);
    endfunction

    function automatic bit iss_match(int r);
        return issue_valid && (int'(issue_tag) != FREE) && (int'(issue_reg) == r);
    endfunction

    task automatic model_check();
        int g;
        logic [NREQ-1:0]    eg;
        logic [NREG-1:0]    ed, el;
        logic [NREG*LW-1:0] ew, gw;
        g  = model_grant();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        ed = '0; el = '0; ew = '0; gw = '0;
        for (int r = 0; r < NREG; r++) begin
            ed[r] = wb_match(r);
            el[r] = ed[r] | iss_match(r);
            if (el[r]) begin
                ew[r*LW +: LW] = iss_match(r) ? issue_tag : LW'(FREE);
                gw[r*LW +: LW] = reg_wlabel[r*LW +: LW];
            end
        end
        check("gnt", fu_gnt, eg);
        check("cdb_valid", cdb_valid, m_cv);
        if (m_cv) begin
            check("cdb_data", cdb_data, m_cd);
            check("cdb_tag", cdb_tag, m_ct);
            check("reg_wdata", reg_wdata, m_cd);
        end
        check("data_ctrl", reg_data_ctrl, ed);
        check("label_ctrl", reg_label_ctrl, el);
        check("wlabel", gw, ew);
    endtask

    task automatic model_update();
        int g;
        if (!rst_n) begin
            model_reset();
        end else begin
            g = model_grant();
            for (int r = 0; r < NREG; r++) begin
                if (iss_match(r))     m_lbl[r] = issue_tag;
                else if (wb_match(r)) m_lbl[r] = FREE;
            end
            m_cv     = (g >= 0);
            m_last_g = g;
            if (g >= 0) begin
                m_cd  = fu_data[g*DW +: DW];
                m_ct  = fu_tag[g*LW +: LW];
                m_ptr = g;
            end
        end
    endtask

    // Check mid-cycle against the model, then advance one clock.
    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    logic [NREQ-1:0] rr_exp [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        rst_n = 1'b0;
        issue_valid = 1'b0; issue_reg = '0; issue_tag = '0;
        fu_req = '0; fu_data = '0; fu_tag = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cdb_valid", cdb_valid, 1'b0);
        check("rst_cdb_tag", cdb_tag, 2'b11);
        check("rst_data_ctrl", reg_data_ctrl, 8'h00);
        check("rst_label_ctrl", reg_label_ctrl, 8'h00);
        check("rst_wlabel", reg_wlabel, 16'hFFFF);
        rst_n = 1'b1;
        cycle();

        // Round-robin with all three requesting
        fu_req  = 3'b111;
        fu_data = {12'h333, 12'h222, 12'h111};
        fu_tag  = {2'b11, 2'b11, 2'b11};
        for (int k = 0; k < 4; k++) begin
            #2;
            check("rr_gnt", fu_gnt, rr_exp[k]);
            cycle();
        end
        fu_req = '0;

        // Issue reg 5 with label 1
        issue_valid = 1'b1; issue_reg = 3'd5; issue_tag = 2'd1;
        #2;
        check("iss_label_ctrl", reg_label_ctrl, 8'h20);
        check("iss_wlabel5", reg_wlabel[11:10], 2'b01);
        cycle();

        // FU1 returns 0xABC with label 1
        issue_valid = 1'b0;
        fu_req = 3'b010; fu_data[23:12] = 12'hABC; fu_tag[3:2] = 2'b01;
        #2;
        check("fu1_gnt", fu_gnt, 3'b010);
        cycle();
        fu_req = '0;
        #2;
        check("bc_valid", cdb_valid, 1'b1);
        check("bc_data", cdb_data, 12'hABC);
        check("bc_data_ctrl", reg_data_ctrl, 8'h20);
        check("bc_wlabel5", reg_wlabel[11:10], 2'b11);
        cycle();

        // Multi-match: regs 2 and 6 share label 0
        issue_valid = 1'b1; issue_reg = 3'd2; issue_tag = 2'd0;
        cycle();
        issue_reg = 3'd6;
        cycle();
        issue_valid = 1'b0;
        fu_req = 3'b001; fu_data[11:0] = 12'h123; fu_tag[1:0] = 2'b00;
        cycle();
        fu_req = '0;
        #2;
        check("mm_data_ctrl", reg_data_ctrl, 8'h44);
        check("mm_data", reg_wdata, 12'h123);
        cycle();
        // Both labels freed: the same label now matches nothing
        fu_req = 3'b001;
        cycle();
        fu_req = '0;
        #2;
        check("mm_freed", reg_data_ctrl, 8'h00);
        cycle();

        // Collision: reg 3 waits on label 2 while being reissued with label 0
        issue_valid = 1'b1; issue_reg = 3'd3; issue_tag = 2'd2;
        cycle();
        issue_valid = 1'b0;
        fu_req = 3'b100; fu_data[35:24] = 12'h5A5; fu_tag[5:4] = 2'b10;
        cycle();
        fu_req = '0;
        issue_valid = 1'b1; issue_reg = 3'd3; issue_tag = 2'd0;
        #2;
        check("col_data_ctrl", reg_data_ctrl, 8'h08);
        check("col_label_ctrl", reg_label_ctrl, 8'h08);
        check("col_wlabel3", reg_wlabel[7:6], 2'b00);
        cycle();
        issue_valid = 1'b0;
        fu_req = 3'b001; fu_data[11:0] = 12'h777; fu_tag[1:0] = 2'b00;
        cycle();
        fu_req = '0;
        #2;
        check("col_table3", reg_data_ctrl, 8'h08);
        cycle();

        // Asynchronous reset while a broadcast is on the bus
        issue_valid = 1'b1; issue_reg = 3'd5; issue_tag = 2'd1;
        cycle();
        issue_valid = 1'b0;
        fu_req = 3'b001; fu_data[11:0] = 12'h0F0; fu_tag[1:0] = 2'b01;
        cycle();
        fu_req = '0;
        #1;
        check("pre_rst_valid", cdb_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", cdb_valid, 1'b0);
        check("arst_data_ctrl", reg_data_ctrl, 8'h00);
        check("arst_cdb_tag", cdb_tag, 2'b11);
        model_reset();
        cycle();
        rst_n = 1'b1;
        fu_req = 3'b001; fu_data[11:0] = 12'h0F0; fu_tag[1:0] = 2'b01;
        cycle();
        fu_req = '0;
        #2;
        check("post_rst_valid", cdb_valid, 1'b1);
        check("post_rst_nowrite", reg_data_ctrl, 8'h00);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if (n == 500) begin
                fu_req = '0; issue_valid = 1'b0;
                rst_n = 1'b0;
                model_reset();
                cycle();
                rst_n = 1'b1;
            end
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_reg   = RAW'($urandom_range(0, NREG - 1));
            issue_tag   = LW'($urandom_range(0, 3));
            for (int i = 0; i < NREQ; i++) begin
                if (!fu_req[i] && ($urandom_range(0, 2) == 0)) begin
                    fu_req[i] = 1'b1;
                    fu_data[i*DW +: DW] = DW'($urandom);
                    fu_tag[i*LW +: LW]  = LW'($urandom_range(0, 3));
                end
            end
            cycle();
            if (m_last_g >= 0) fu_req[m_last_g] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
